pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, consecutive data-memory wait cycles before fault (legal range 1..255).
REQ-002 Parameter: PERF_W, default 16, width of each performance counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: id_opcode  input  7  opcode of instruction in ID (RV32I encodings: 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0110011).
REQ-006 Port: id_rs1, id_rs2  input  5 each  source register fields of ID instruction.
REQ-007 Port: ex_mem_read  input  1  EX instruction is a load.
REQ-008 Port: ex_rd  input  5  destination register of EX instruction.
REQ-009 Port: ex_branch_taken  input  1  EX resolved taken branch, JAL or JALR.
REQ-010 Port: dmem_req  input  1  MEM stage has a valid data-memory access.
REQ-011 Port: dmem_ready  input  1  data memory completes the access this cycle.
REQ-012 Port: perf_clr  input  1  synchronous clear of performance counters.
REQ-013 Port: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  output  1 each  hold the PC or the named pipeline register.
REQ-014 Port: if_id_flush, id_ex_flush  output  1 each  load bubble into named register.
REQ-015 Port: mem_wb_bubble  output  1  insert bubble into MEM/WB.
REQ-016 Port: mem_fault  output  1  memory timeout occurred; pipeline halted.
REQ-017 Port: stall_cnt, flush_cnt, loaduse_cnt  output  PERF_W each  performance counters.

Function
REQ-018 Source use decoded from id_opcode: LUI, AUIPC, JAL use none; OP-IMM, LOAD, JALR use rs1; STORE, BRANCH, OP use rs1 and rs2; other opcodes use none.
REQ-019 load_use = ex_mem_read AND ex_rd != 0 AND ex_rd equals any used source register.
REQ-020 freeze = dmem_req AND NOT dmem_ready.
REQ-021 FSM states: RUN, FAULT; reset state RUN; FAULT exits only via rst_n.
REQ-022 All outputs combinational from current state and inputs except counters and mem_fault; zero added latency.
REQ-023 RUN, priority 1, freeze: all four stalls = 1, mem_wb_bubble = 1, flushes = 0.
REQ-024 RUN, priority 2, ex_branch_taken and not freeze: if_id_flush = id_ex_flush = 1, all stalls = 0, load_use ignored.
REQ-025 RUN, priority 3, load_use only: pc_stall = if_id_stall = 1, id_ex_flush = 1, all other outputs 0; exactly one cycle per hazard occurrence.
REQ-026 RUN, none of the above: all stall/flush/bubble outputs 0.
REQ-027 wait_cnt (8 bit, internal) increments each freeze cycle in RUN; clears to 0 on any RUN cycle without freeze.
REQ-028 A freeze cycle in RUN with wait_cnt == MEM_TIMEOUT-1 moves state to FAULT at the ending clock edge.
REQ-029 FAULT: all four stalls = 1, mem_wb_bubble = 1, flushes = 0, mem_fault = 1; inputs ignored.
REQ-030 stall_cnt +1 per RUN cycle with freeze or REQ-025 stall; flush_cnt +1 per REQ-024 cycle; loaduse_cnt +1 per REQ-025 cycle; no counting in FAULT.
REQ-031 Counters saturate at all-ones; perf_clr has priority over increment and clears all three to 0.

Reset
REQ-032 rst_n low, asynchronously: state = RUN, wait_cnt = 0, all counters = 0, mem_fault = 0; combinational outputs follow RUN rules.
REQ-033 Reset asserted mid-freeze or in FAULT aborts it; first cycle after release evaluates RUN rules from fresh inputs.

Verification
REQ-034 ex_mem_read=1, ex_rd=5, id_opcode=0110011, id_rs2=5 -> pc_stall=if_id_stall=id_ex_flush=1 one cycle; loaduse_cnt=1, stall_cnt=1.
REQ-035 Same with id_opcode=0110111, id_rs1=5; then ex_rd=0, id_rs1=0, opcode 0010011 -> no stall, counters unchanged.
REQ-036 ex_branch_taken=1 with load_use true -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1, loaduse_cnt=0.
REQ-037 dmem_req=1, dmem_ready=0 three cycles, then dmem_ready=1 -> four stalls high exactly 3 cycles; stall_cnt=3; no fault.
REQ-038 MEM_TIMEOUT=4, dmem_ready=0 held -> mem_fault=1 from cycle 5, stalls held; rst_n pulse low -> mem_fault=0, counters 0.
REQ-039 Force 2^PERF_W+2 load-use cycles -> loaduse_cnt holds all-ones; perf_clr=1 with load_use -> next value 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/bubble control with memory timeout fault and perf counters
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        id_opcode,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    input  logic              perf_clr,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_wb_bubble,
    output logic              mem_fault,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
    output logic [PERF_W-1:0] loaduse_cnt
);

    typedef enum logic {RUN, FAULT} state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [PERF_W-1:0] loaduse_cnt_q, loaduse_cnt_d;

    logic use_rs1, use_rs2, load_use, freeze;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (id_opcode)
            7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
            7'b0100011, 7'b1100011, 7'b0110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((use_rs1 && (ex_rd == id_rs1)) || (use_rs2 && (ex_rd == id_rs2)));
    assign freeze   = dmem_req && !dmem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        loaduse_cnt_d = loaduse_cnt_q;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    pc_stall      = 1'b1;
                    if_id_stall   = 1'b1;
                    id_ex_stall   = 1'b1;
                    ex_mem_stall  = 1'b1;
                    mem_wb_bubble = 1'b1;
                    wait_cnt_d    = wait_cnt_q + 8'd1;
                    stall_cnt_d   = sat_inc(stall_cnt_q);
                    if (wait_cnt_q == TIMEOUT_M1) state_d = FAULT;
                end else begin
                    wait_cnt_d = 8'd0;
                    // A taken branch squashes the dependent instruction, so load-use is moot.
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_cnt_d = sat_inc(flush_cnt_q);
                    end else if (load_use) begin
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        id_ex_flush   = 1'b1;
                        stall_cnt_d   = sat_inc(stall_cnt_q);
                        loaduse_cnt_d = sat_inc(loaduse_cnt_q);
                    end
                end
                if (perf_clr) begin
                    stall_cnt_d   = '0;
                    flush_cnt_d   = '0;
                    loaduse_cnt_d = '0;
                end
            end
            FAULT: begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            loaduse_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            loaduse_cnt_q <= loaduse_cnt_d;
        end
    end

    assign mem_fault   = (state_q == FAULT);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign loaduse_cnt = loaduse_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int PW = 4;

    // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_FRZ  = 7'b1111001;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    id_opcode = OP_IMM;
    logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
    logic          ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic          dmem_req = 1'b0, dmem_ready = 1'b0, perf_clr = 1'b0;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic          if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault;
    logic [PW-1:0] stall_cnt, flush_cnt, loaduse_cnt;

    typedef struct {
        int            id;
        logic [6:0]    ctrl;
        logic          fault;
        logic [PW-1:0] st, fl, lu;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_step = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .mem_fault(mem_fault),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .loaduse_cnt(loaduse_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rstn, input logic [6:0] opc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic mr, input logic [4:0] rd,
                        input logic br, input logic req, input logic rdy, input logic clr,
                        input logic [6:0] e_ctrl, input logic e_fault,
                        input int e_st, input int e_fl, input int e_lu);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rstn; id_opcode = opc; id_rs1 = rs1; id_rs2 = rs2;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
        dmem_req = req; dmem_ready = rdy; perf_clr = clr;
        e.id = n_step; e.ctrl = e_ctrl; e.fault = e_fault;
        e.st = PW'(e_st); e.fl = PW'(e_fl); e.lu = PW'(e_lu);
        exp_q.push_back(e);
        n_step++;
    endtask

    task automatic idle(input int e_st, input int e_fl, input int e_lu);
        step(1'b1, OP_IMM, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             C_NONE, 1'b0, e_st, e_fl, e_lu);
    endtask

    task automatic frz(input logic e_fault, input int e_st, input int e_fl, input int e_lu);
        step(1'b1, OP_IMM, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
             C_FRZ, e_fault, e_st, e_fl, e_lu);
    endtask

    task automatic chk(input string name, input int id, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ctrl", e.id, int'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                                    if_id_flush, id_ex_flush, mem_wb_bubble}), int'(e.ctrl));
            chk("mem_fault", e.id, int'(mem_fault), int'(e.fault));
            chk("stall_cnt", e.id, int'(stall_cnt), int'(e.st));
            chk("flush_cnt", e.id, int'(flush_cnt), int'(e.fl));
            chk("loaduse_cnt", e.id, int'(loaduse_cnt), int'(e.lu));
        end
    end

    initial begin
        // in reset
        step(1'b0, OP_IMM, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 0, 0, 0);
        // R-type rs2 load-use, then clean
        step(1'b1, OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 0, 0, 0);
        idle(1, 0, 1);
        // LUI ignores rs1; rd x0 never hazards
        step(1'b1, OP_LUI, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1, 0, 1);
        step(1'b1, OP_IMM, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1, 0, 1);
        // LOAD rs1 and STORE rs2 hazards; OP-IMM ignores rs2
        step(1'b1, OP_LD, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 1, 0, 1);
        step(1'b1, OP_ST, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 2, 0, 2);
        step(1'b1, OP_IMM, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 3, 0, 3);
        // branch overrides load-use
        step(1'b1, OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_BR, 1'b0, 3, 0, 3);
        idle(3, 1, 3);
        // freeze beats branch and load-use; three freeze cycles then ready
        step(1'b1, OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 3, 1, 3);
        frz(1'b0, 4, 1, 3);
        frz(1'b0, 5, 1, 3);
        step(1'b1, OP_IMM, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE, 1'b0, 6, 1, 3);
        // wait count must restart after a ready cycle: three more freezes, no fault
        frz(1'b0, 6, 1, 3);
        frz(1'b0, 7, 1, 3);
        frz(1'b0, 8, 1, 3);
        idle(9, 1, 3);
        // four freezes reach the timeout
        frz(1'b0, 9, 1, 3);
        frz(1'b0, 10, 1, 3);
        frz(1'b0, 11, 1, 3);
        frz(1'b0, 12, 1, 3);
        // FAULT ignores inputs and stops counting
        step(1'b1, OP_IMM, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_FRZ, 1'b1, 13, 1, 3);
        step(1'b1, OP_R, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b1, 13, 1, 3);
        // reset pulse aborts FAULT
        step(1'b0, OP_IMM, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 0, 0, 0);
        // load-use saturation
        for (int i = 0; i < (1 << PW) + 2; i++) begin
            int s;
            s = (i > 15) ? 15 : i;
            step(1'b1, OP_R, 5'd2, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, s, 0, s);
        end
        // clear wins over increment
        step(1'b1, OP_R, 5'd2, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, C_LU, 1'b0, 15, 0, 15);
        idle(0, 0, 0);
        step(1'b1, OP_R, 5'd2, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 0, 0, 0);
        idle(1, 0, 1);
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
